spi_master_rx: RTL and testbench

SPI_MASTER_RX -- requirements
Module: spi_master_rx

---
 rtl/spi_master_rx.sv | 210 +++++++++++++++++++++
 tb/tb_spi_master_rx.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_rx.sv
// SPI master receiver: reads one 32-bit word per transfer (SCK idle low, sample on rise, MSB first).
// Optional SPI_MASTER_RX_FIFO_EN swaps the single holding register for a 2-entry output FIFO.
module spi_master_rx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        ready_o,
    output logic        spi_cs_n_o,
    output logic        spi_sck_o,
    input  logic        spi_sdi_i,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i
);

    // state | meaning
    // IDLE  | waiting for start_i, chip select high, SCK low
    // SETUP | chip select low, first half-period before the first SCK rise
    // SHIFT | SCK toggling every half-period, sample on each rise, 64 edges
    // TAIL  | last fall done, SCK low, chip select still low for a half-period
    // GAP   | chip select high for a half-period before returning to IDLE

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_div;
    logic [5:0]  r_edge;
    logic        r_sck;
    logic        r_cs_n;
    logic [31:0] r_shift;

    logic w_tc;
    logic w_accept;
    logic w_load;
    logic w_sck_toggle;
    logic w_sample;
    logic w_push;
    logic w_pop;
    logic w_cs_low;
    logic w_cs_high;
    logic w_last_edge;
    logic w_store_free;

    assign w_tc        = (r_div == 8'd0);
    assign w_last_edge = (r_edge == 6'd63);
    assign w_pop       = data_valid_o && data_ready_i;
    assign ready_o     = (r_state == IDLE) && w_store_free;
    assign w_accept    = start_i && ready_o;
    assign spi_sck_o   = r_sck;
    assign spi_cs_n_o  = r_cs_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_sck_toggle = 1'b0;
        w_sample     = 1'b0;
        w_push       = 1'b0;
        w_cs_low     = 1'b0;
        w_cs_high    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                    w_cs_low    = 1'b1;
                end
            end
            SETUP: begin
                if (w_tc) begin
                    w_state_nxt  = SHIFT;
                    w_load       = 1'b1;
                    w_sck_toggle = 1'b1;
                    w_sample     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_tc) begin
                    w_load       = 1'b1;
                    w_sck_toggle = 1'b1;
                    w_sample     = !r_sck;
                    // the 64th edge is always a fall, leaving SCK low for TAIL
                    if (w_last_edge) begin
                        w_state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                if (w_tc) begin
                    w_state_nxt = GAP;
                    w_load      = 1'b1;
                    w_cs_high   = 1'b1;
                    w_push      = 1'b1;
                end
            end
            GAP: begin
                if (w_tc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= 8'd0;
            r_edge  <= 6'd0;
            r_sck   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_shift <= 32'd0;
        end else begin
            if (w_load) begin
                r_div <= DIV_LOAD;
            end else if (!w_tc) begin
                r_div <= r_div - 8'd1;
            end
            // 64 toggles wrap the 6-bit counter back to zero for the next transfer
            if (w_sck_toggle) begin
                r_sck  <= !r_sck;
                r_edge <= r_edge + 6'd1;
            end
            if (w_sample) begin
                r_shift <= {r_shift[30:0], spi_sdi_i};
            end
            if (w_cs_low) begin
                r_cs_n <= 1'b0;
            end else if (w_cs_high) begin
                r_cs_n <= 1'b1;
            end
        end
    end

`ifdef SPI_MASTER_RX_FIFO_EN
    logic [31:0] r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    assign w_store_free = (r_count != 2'd2);
    assign data_o       = r_fifo[r_rd_ptr];
    assign data_valid_o = (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0] <= 32'd0;
            r_fifo[1] <= 32'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            // a push always has room: a transfer only starts with fewer than 2 entries held
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_shift;
                r_wr_ptr         <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end
`else
    logic [31:0] r_hold;
    logic        r_hold_vld;

    assign w_store_free = !r_hold_vld;
    assign data_o       = r_hold;
    assign data_valid_o = r_hold_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= 32'd0;
            r_hold_vld <= 1'b0;
        end else begin
            if (w_push) begin
                r_hold     <= r_shift;
                r_hold_vld <= 1'b1;
            end else if (w_pop) begin
                r_hold_vld <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_rx.sv
// Scoreboard bench for spi_master_rx: transaction-level timing model plus SPI slave models.
// Covers both storage builds; SPI_MASTER_RX_FIFO_EN selects which directed scenarios run.
module tb_spi_master_rx;
    localparam int DIV = 2;
`ifdef SPI_MASTER_RX_FIFO_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        start_i      = 1'b0;
    logic        data_ready_i = 1'b0;
    logic        spi_sdi_i;
    logic        ready_o;
    logic        spi_cs_n_o;
    logic        spi_sck_o;
    logic        data_valid_o;
    logic [31:0] data_o;

    logic        start1 = 1'b0;
    logic        sdi1;
    logic        ready1;
    logic        cs1;
    logic        sck1;
    logic        valid1;
    logic [31:0] data1;

    spi_master_rx #(.CLK_DIV(DIV)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .spi_cs_n_o   (spi_cs_n_o),
        .spi_sck_o    (spi_sck_o),
        .spi_sdi_i    (spi_sdi_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i)
    );

    spi_master_rx #(.CLK_DIV(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start1),
        .ready_o      (ready1),
        .spi_cs_n_o   (cs1),
        .spi_sck_o    (sck1),
        .spi_sdi_i    (sdi1),
        .data_o       (data1),
        .data_valid_o (valid1),
        .data_ready_i (1'b0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transfer occupies the block for 66*DIV cycles from acceptance,
    // its word lands in storage 65*DIV cycles after acceptance; storage holds CAP words.
    logic [31:0] slave_word = 32'd0;
    logic [31:0] exp_q[$];
    int          m_busy    = 0;
    int          m_occ     = 0;
    int          m_accepts = 0;
    bit          m_acc;
    bit          m_pop;
    bit          m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_occ  = 0;
        end else begin
            m_pop  = (m_occ > 0) && (data_ready_i === 1'b1);
            m_acc  = (m_busy == 0) && (m_occ < CAP) && (start_i === 1'b1);
            m_push = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                m_push = (m_busy == DIV);
            end
            if (m_acc) begin
                m_busy = 66 * DIV;
                exp_q.push_back(slave_word);
                m_accepts++;
            end
            m_occ = m_occ + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: per-cycle handshake checks and scoreboard pop on each consumer handshake.
    int sb_rd  = 0;
    bit mon_en = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_rd = exp_q.size();
        end else if (mon_en) begin
            check("ready_o", ready_o, 32'((m_busy == 0) && (m_occ < CAP)));
            check("data_valid_o", data_valid_o, 32'(m_occ > 0));
            if (data_valid_o === 1'b1 && data_ready_i === 1'b1) begin
                if (sb_rd < exp_q.size()) begin
                    check("popped_word", data_o, exp_q[sb_rd]);
                    sb_rd++;
                end else begin
                    check("pop_without_expected_word", 32'(exp_q.size() - sb_rd), 1);
                end
            end
        end
    end

    // Slave for the main instance: loads the word on CS fall, shifts on each SCK fall.
    logic [31:0] s_sh     = 32'd0;
    int          s_rises  = 0;
    int          cs_falls = 0;
    logic        s_cs_q;
    logic        s_sck_q;

    assign spi_sdi_i = s_sh[31];

    always @(spi_cs_n_o or spi_sck_o) begin
        if (spi_cs_n_o !== s_cs_q) begin
            if (spi_cs_n_o === 1'b0) begin
                s_sh    = slave_word;
                s_rises = 0;
                cs_falls++;
            end else if (spi_cs_n_o === 1'b1 && s_cs_q === 1'b0 && rst_n === 1'b1) begin
                check("sck_rises_per_transfer", s_rises, 32);
            end
            s_cs_q = spi_cs_n_o;
        end
        if (spi_sck_o !== s_sck_q) begin
            if (rst_n === 1'b1) check("sck_toggle_with_cs_high", spi_cs_n_o, 0);
            if (spi_sck_o === 1'b1) begin
                s_rises++;
            end else if (s_sck_q === 1'b1 && spi_cs_n_o === 1'b0) begin
                s_sh = s_sh << 1;
            end
            s_sck_q = spi_sck_o;
        end
    end

    // Slave for the CLK_DIV=1 instance, also timestamps the first two SCK rises.
    logic [31:0] s1_sh    = 32'd0;
    int          s1_rises = 0;
    longint      s1_t0    = 0;
    longint      s1_t1    = 0;
    logic        s1_cs_q;
    logic        s1_sck_q;

    assign sdi1 = s1_sh[31];

    always @(cs1 or sck1) begin
        if (cs1 !== s1_cs_q) begin
            if (cs1 === 1'b0) begin
                s1_sh    = 32'h8000_0001;
                s1_rises = 0;
            end else if (cs1 === 1'b1 && s1_cs_q === 1'b0 && rst_n === 1'b1) begin
                check("div1_sck_rises", s1_rises, 32);
            end
            s1_cs_q = cs1;
        end
        if (sck1 !== s1_sck_q) begin
            if (sck1 === 1'b1) begin
                if (s1_rises == 0) s1_t0 = longint'($time);
                if (s1_rises == 1) s1_t1 = longint'($time);
                s1_rises++;
            end else if (s1_sck_q === 1'b1 && cs1 === 1'b0) begin
                s1_sh = s1_sh << 1;
            end
            s1_sck_q = sck1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accepts(input int n);
        int t = 0;
        while (m_accepts < n && t < 2000) begin
            tick();
            t++;
        end
        check("start_accepted", 32'(m_accepts >= n), 1);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (data_valid_o !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        check(name, data_valid_o, 1);
    endtask

    task automatic pop_one();
        data_ready_i = 1'b1;
        tick();
        data_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          f0;
        int          a0;
        int          t;
        logic [31:0] w2;

        #12;
        check("rst_cs_n", spi_cs_n_o, 1);
        check("rst_sck", spi_sck_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_data", data_o, 32'd0);
        check("rst_ready", ready_o, 1);
        check("div1_rst_ready", ready1, 1);
        #6 rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // CLK_DIV=1 instance: SCK period 2 cycles, word valid 65 cycles after accept
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        c0 = cyc;
        t = 0;
        while (valid1 !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        check("div1_valid_cycle", 32'(cyc - c0), 65);
        check("div1_data", data1, 32'h8000_0001);
        check("div1_sck_period", 32'(s1_t1 - s1_t0), 20);

        // single transfer: valid at 130, ready back at 132
        slave_word = 32'hA5C3_0F81;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        c0 = cyc;
        t = 0;
        while (data_valid_o !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        check("valid_cycle", 32'(cyc - c0), 130);
        check("word_a5c3", data_o, 32'hA5C3_0F81);
        data_ready_i = 1'b1;
        t = 0;
        while (ready_o !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        data_ready_i = 1'b0;
        check("ready_cycle", 32'(cyc - c0), 132);

`ifdef SPI_MASTER_RX_FIFO_EN
        // two words held, third start ignored, pops in order
        a0 = m_accepts;
        slave_word = 32'h1111_1111;
        start_i = 1'b1;
        wait_accepts(a0 + 1);
        slave_word = 32'h2222_2222;
        wait_accepts(a0 + 2);
        slave_word = 32'h3333_3333;
        t = 0;
        while (m_occ < 2 && t < 400) begin
            tick();
            t++;
        end
        f0 = cs_falls;
        repeat (200) tick();
        check("no_cs_fall_when_full", cs_falls, f0);
        check("ready_low_when_full", ready_o, 0);
        check("fifo_head_first", data_o, 32'h1111_1111);
        start_i = 1'b0;
        data_ready_i = 1'b1;
        tick();
        check("fifo_head_second", data_o, 32'h2222_2222);
        tick();
        data_ready_i = 1'b0;
        check("fifo_empty_after_pops", data_valid_o, 0);

        // pop on the same cycle as a push with one entry held
        a0 = m_accepts;
        slave_word = $urandom;
        start_i = 1'b1;
        wait_accepts(a0 + 1);
        w2 = $urandom;
        slave_word = w2;
        wait_accepts(a0 + 2);
        start_i = 1'b0;
        t = 0;
        while (m_busy != DIV + 1 && t < 400) begin
            tick();
            t++;
        end
        check("one_held_before_push", data_valid_o, 1);
        pop_one();
        check("push_pop_still_valid", data_valid_o, 1);
        check("push_pop_newer_word", data_o, w2);
        pop_one();
        check("push_pop_drained", data_valid_o, 0);
`else
        // start held while the holding register is full must wait for the pop
        a0 = m_accepts;
        slave_word = $urandom;
        start_i = 1'b1;
        data_ready_i = 1'b0;
        wait_accepts(a0 + 1);
        slave_word = 32'h0000_0001;
        wait_valid("first_word_valid");
        f0 = cs_falls;
        repeat (200) tick();
        check("no_cs_fall_while_full", cs_falls, f0);
        check("ready_low_while_full", ready_o, 0);
        pop_one();
        wait_accepts(a0 + 2);
        start_i = 1'b0;
        wait_valid("second_word_valid");
        check("second_word", data_o, 32'h0000_0001);
        pop_one();
`endif

        // reset after the 10th SCK rise discards the transfer
        slave_word = $urandom;
        a0 = m_accepts;
        start_i = 1'b1;
        wait_accepts(a0 + 1);
        start_i = 1'b0;
        t = 0;
        while (s_rises < 10 && t < 200) begin
            tick();
            t++;
        end
        check("reached_tenth_rise", s_rises, 10);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", spi_cs_n_o, 1);
        check("async_rst_sck", spi_sck_o, 0);
        check("async_rst_valid", data_valid_o, 0);
        check("async_rst_data", data_o, 32'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("ready_after_reset", ready_o, 1);
        slave_word = 32'hFFFF_FFFF;
        a0 = m_accepts;
        start_i = 1'b1;
        wait_accepts(a0 + 1);
        start_i = 1'b0;
        wait_valid("ffff_valid");
        check("ffff_word", data_o, 32'hFFFF_FFFF);
        pop_one();

        // randomized words, start requests and consumer back-pressure
        a0 = m_accepts;
        t = 0;
        while (m_accepts < a0 + 12 && t < 6000) begin
            slave_word   = $urandom;
            start_i      = 1'($urandom_range(0, 1));
            data_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            t++;
        end
        check("random_transfers_issued", 32'(m_accepts - a0), 12);
        start_i = 1'b0;
        data_ready_i = 1'b1;
        t = 0;
        while ((m_busy != 0 || m_occ != 0) && t < 2000) begin
            tick();
            t++;
        end
        data_ready_i = 1'b0;
        tick();
        check("scoreboard_drained", 32'(exp_q.size() - sb_rd), 0);
        check("final_valid_low", data_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
